ntt_core: RTL and testbench

- Iterative negacyclic number-theoretic transform engine over Z_q for polynomials of RING_SIZE = 2^RING_DEPTH coefficients.
- Twiddle tables, modulus and N^-1 are streamed in once through a single data port; the polynomial is then streamed in.
- A forward (NTT) or inverse (INTT) run is started by a one-cycle pulse. The result streams out after a done pulse.
- Used as the polynomial-multiplication core of the accelerator datapath.

---
 rtl/ntt_core.sv | 225 ++++++++++++++++++++++
 tb/tb_ntt_core.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_core.sv
// Iterative negacyclic NTT/INTT engine over Z_q, one butterfly per cycle.
// Twiddles, q and N^-1 are loaded once; results stream out after a done pulse.
module ntt_core #(
  parameter int DATA_SIZE  = 32,
  parameter int RING_DEPTH = 3,
  parameter int PE_DEPTH   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_w,
  input  logic                 load_data,
  input  logic                 start,
  input  logic                 start_intt,
  input  logic [DATA_SIZE-1:0] din,
  output logic                 done,
  output logic [DATA_SIZE-1:0] dout
);

  localparam int RING_SIZE = 1 << RING_DEPTH;
  localparam int TW        = (((1 << (RING_DEPTH - PE_DEPTH)) - 1) + PE_DEPTH) << PE_DEPTH;
  localparam int HALF      = RING_SIZE / 2;
  localparam int IDX_W     = RING_DEPTH;
  localparam int CNT_W     = RING_DEPTH + 1;
  localparam int STG_W     = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_D, S_RUN_NTT, S_RUN_INTT, S_OUTPUT
  } state_t;

  function automatic logic [DATA_SIZE-1:0] mul_mod(input logic [DATA_SIZE-1:0] a,
                                                   input logic [DATA_SIZE-1:0] b,
                                                   input logic [DATA_SIZE-1:0] m);
    logic [2*DATA_SIZE-1:0] p;
    p = {{DATA_SIZE{1'b0}}, a} * {{DATA_SIZE{1'b0}}, b};
    if (m == '0) return '0;
    return DATA_SIZE'(p % {{DATA_SIZE{1'b0}}, m});
  endfunction

  function automatic logic [DATA_SIZE-1:0] add_mod(input logic [DATA_SIZE-1:0] a,
                                                   input logic [DATA_SIZE-1:0] b,
                                                   input logic [DATA_SIZE-1:0] m);
    logic [DATA_SIZE:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, m}) ? DATA_SIZE'(s - {1'b0, m}) : DATA_SIZE'(s);
  endfunction

  function automatic logic [DATA_SIZE-1:0] sub_mod(input logic [DATA_SIZE-1:0] a,
                                                   input logic [DATA_SIZE-1:0] b,
                                                   input logic [DATA_SIZE-1:0] m);
    return (a >= b) ? (a - b) : (a - b + m);
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STG_W-1:0]     stage_q, stage_d;
  logic [IDX_W-1:0]     bfly_q, bfly_d;
  logic                 scale_q, scale_d;
  logic                 done_q, done_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic [DATA_SIZE-1:0] q_q, q_d;
  logic [DATA_SIZE-1:0] ninv_q, ninv_d;

  logic [DATA_SIZE-1:0] w_mem    [TW];
  logic [DATA_SIZE-1:0] winv_mem [TW];
  logic [DATA_SIZE-1:0] a_mem    [RING_SIZE];

  logic [IDX_W-1:0]     t_sh, grp, off, idx_lo, idx_hi, tw_idx, tw_waddr, cnt_idx;
  logic                 last_bfly, w_we, winv_we, a_we_lo, a_we_hi;
  logic [IDX_W-1:0]     a_addr_lo;
  logic [DATA_SIZE-1:0] a_wd_lo, a_wd_hi, u, v, vw, a_rd;

  // Butterfly k of stage s: pair (i, i+t) with t = N>>(s+1), group j = k/t.
  always_comb begin
    t_sh      = IDX_W'(RING_DEPTH - 1) - IDX_W'(stage_q);
    grp       = bfly_q >> t_sh;
    off       = bfly_q & ((IDX_W'(1) << t_sh) - IDX_W'(1));
    idx_lo    = (grp << (t_sh + IDX_W'(1))) | off;
    idx_hi    = idx_lo | (IDX_W'(1) << t_sh);
    tw_idx    = (IDX_W'(1) << stage_q) - IDX_W'(1) + grp;
    last_bfly = (bfly_q == IDX_W'(HALF - 1));
    cnt_idx   = cnt_q[IDX_W-1:0];
    // TW = N-1, so the inverse-table offset cnt-TW is cnt+1 modulo N.
    tw_waddr  = (cnt_q < CNT_W'(TW)) ? cnt_idx : cnt_idx + IDX_W'(1);
    u         = a_mem[idx_lo];
    v         = a_mem[idx_hi];
    vw        = mul_mod(v, w_mem[tw_idx], q_q);
    a_rd      = a_mem[cnt_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_w)          state_d = S_LOAD_W;
        else if (load_data)  state_d = S_LOAD_D;
        else if (start)      state_d = S_RUN_NTT;
        else if (start_intt) state_d = S_RUN_INTT;
      end
      S_LOAD_W:   if (cnt_q == CNT_W'(2 * TW + 1)) state_d = S_IDLE;
      S_LOAD_D:   if (cnt_q == CNT_W'(RING_SIZE - 1)) state_d = S_IDLE;
      S_RUN_NTT:  if (last_bfly && stage_q == STG_W'(RING_DEPTH - 1)) state_d = S_OUTPUT;
      S_RUN_INTT: if (scale_q && cnt_q == CNT_W'(RING_SIZE - 1)) state_d = S_OUTPUT;
      S_OUTPUT:   if (cnt_q == CNT_W'(RING_SIZE - 1)) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    scale_d   = scale_q;
    done_d    = 1'b0;
    dout_d    = '0;
    q_d       = q_q;
    ninv_d    = ninv_q;
    w_we      = 1'b0;
    winv_we   = 1'b0;
    a_we_lo   = 1'b0;
    a_we_hi   = 1'b0;
    a_addr_lo = idx_lo;
    a_wd_lo   = '0;
    a_wd_hi   = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        bfly_d  = '0;
        scale_d = 1'b0;
        stage_d = (state_d == S_RUN_INTT) ? STG_W'(RING_DEPTH - 1) : '0;
      end
      S_LOAD_W: begin
        if (cnt_q < CNT_W'(TW))               w_we    = 1'b1;
        else if (cnt_q < CNT_W'(2 * TW))      winv_we = 1'b1;
        else if (cnt_q == CNT_W'(2 * TW))     q_d     = din;
        else                                  ninv_d  = din;
      end
      S_LOAD_D: begin
        a_we_lo   = 1'b1;
        a_addr_lo = cnt_idx;
        a_wd_lo   = din;
      end
      S_RUN_NTT: begin
        a_we_lo = 1'b1;
        a_we_hi = 1'b1;
        a_wd_lo = add_mod(u, vw, q_q);
        a_wd_hi = sub_mod(u, vw, q_q);
        bfly_d  = bfly_q + IDX_W'(1);
        if (last_bfly) begin
          bfly_d  = '0;
          stage_d = stage_q + STG_W'(1);
          if (stage_q == STG_W'(RING_DEPTH - 1)) begin
            done_d = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      S_RUN_INTT: begin
        if (!scale_q) begin
          a_we_lo = 1'b1;
          a_we_hi = 1'b1;
          a_wd_lo = add_mod(u, v, q_q);
          a_wd_hi = mul_mod(sub_mod(u, v, q_q), winv_mem[tw_idx], q_q);
          bfly_d  = bfly_q + IDX_W'(1);
          if (last_bfly) begin
            bfly_d = '0;
            if (stage_q == '0) begin
              scale_d = 1'b1;
              cnt_d   = '0;
            end else begin
              stage_d = stage_q - STG_W'(1);
            end
          end
        end else begin
          a_we_lo   = 1'b1;
          a_addr_lo = cnt_idx;
          a_wd_lo   = mul_mod(a_rd, ninv_q, q_q);
          if (cnt_q == CNT_W'(RING_SIZE - 1)) begin
            done_d = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      S_OUTPUT: dout_d = a_rd;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
      scale_q <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      q_q     <= '0;
      ninv_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      scale_q <= scale_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      q_q     <= q_d;
      ninv_q  <= ninv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)    w_mem[tw_waddr]    <= din;
    if (winv_we) winv_mem[tw_waddr] <= din;
    if (a_we_lo) a_mem[a_addr_lo]   <= a_wd_lo;
    if (a_we_hi) a_mem[idx_hi]      <= a_wd_hi;
  end

  assign done = done_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_ntt_core.sv
// Self-checking bench for ntt_core: direct-evaluation reference model feeding
// a scoreboard queue that is drained as the result stream comes out.
module tb_ntt_core;

  localparam int D       = 3;
  localparam int N       = 8;
  localparam int TW      = 7;
  localparam int LAT_MAX = (N / 2) * D + N + 32;
  localparam logic [31:0] Q       = 32'd17;
  localparam logic [31:0] PSI     = 32'd3;
  localparam logic [31:0] PSI_INV = 32'd6;
  localparam logic [31:0] NINV    = 32'd15;

  typedef logic [31:0] vec_t [N];

  logic        clk = 1'b0;
  logic        reset, load_w, load_data, start, start_intt;
  logic [31:0] din;
  logic        done;
  logic [31:0] dout;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  vec_t        cur;

  ntt_core #(.DATA_SIZE(32), .RING_DEPTH(D), .PE_DEPTH(0)) dut (
    .clk(clk), .reset(reset), .load_w(load_w), .load_data(load_data),
    .start(start), .start_intt(start_intt), .din(din), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int brv3(input int x);
    return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
  endfunction

  function automatic logic [31:0] pw(input logic [31:0] b, input int e);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < e; i++) r = (r * 64'(b)) % 64'(Q);
    return r[31:0];
  endfunction

  // Output position k holds the evaluation at psi^(2*brv(k)+1).
  task automatic ref_ntt(input vec_t a, output vec_t y);
    logic [63:0] acc;
    for (int k = 0; k < N; k++) begin
      acc = '0;
      for (int i = 0; i < N; i++)
        acc = (acc + 64'(a[i]) * 64'(pw(PSI, ((2 * brv3(k) + 1) * i) % (2 * N)))) % 64'(Q);
      y[k] = acc[31:0];
    end
  endtask

  task automatic ref_intt(input vec_t a, output vec_t y);
    logic [63:0] acc;
    for (int i = 0; i < N; i++) begin
      acc = '0;
      for (int k = 0; k < N; k++)
        acc = (acc + 64'(a[k]) * 64'(pw(PSI_INV, ((2 * brv3(k) + 1) * i) % (2 * N)))) % 64'(Q);
      acc = (acc * 64'(NINV)) % 64'(Q);
      y[i] = acc[31:0];
    end
  endtask

  task automatic do_load_w();
    @(negedge clk);
    load_w = 1'b1;
    @(negedge clk);
    load_w = 1'b0;
    for (int k = 0; k < TW; k++) begin din = pw(PSI, brv3(k + 1)); @(negedge clk); end
    for (int k = 0; k < TW; k++) begin din = pw(PSI_INV, brv3(k + 1)); @(negedge clk); end
    din = Q;    @(negedge clk);
    din = NINV; @(negedge clk);
    din = '0;
  endtask

  task automatic load_vec(input vec_t v, input int start_at);
    @(negedge clk);
    load_data = 1'b1;
    @(negedge clk);
    load_data = 1'b0;
    for (int k = 0; k < N; k++) begin
      din = v[k];
      if (k == start_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    din = '0;
    cur = v;
  endtask

  task automatic check_quiet(input int cycles, input string name);
    logic bad_done;
    logic [31:0] bad_dout;
    bit bad;
    bad = 0; bad_done = 1'b0; bad_dout = '0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (!bad && (done !== 1'b0 || dout !== 32'd0)) begin
        bad = 1; bad_done = done; bad_dout = dout;
      end
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: done=%b dout=%0d while idle, expected done=0 dout=0", name, bad_done, bad_dout);
    end
  endtask

  task automatic run_xform(input bit intt, input int pulse_out_at, input string name, output vec_t got);
    vec_t expv;
    logic [31:0] e;
    int cycles;
    if (intt) ref_intt(cur, expv); else ref_ntt(cur, expv);
    for (int k = 0; k < N; k++) exp_q.push_back(expv[k]);
    cur = expv;
    for (int k = 0; k < N; k++) got[k] = '0;
    @(negedge clk);
    if (intt) start_intt = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_intt = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < LAT_MAX) begin @(negedge clk); cycles++; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: done=%b after %0d cycles, expected 1", name, done, LAT_MAX);
      exp_q.delete();
      return;
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start = 1'b0;
      got[k] = dout;
      e = exp_q.pop_front();
      n_checks++;
      if (dout !== e) begin
        n_fail++;
        $display("FAIL %s_dout[%0d]: got %0d expected %0d", name, k, dout, e);
      end
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_done_width[%0d]: done=%b expected 0", name, k, done);
      end
      if (k == pulse_out_at) start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (dout !== 32'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_tail: dout=%0d done=%b expected 0 0", name, dout, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_w = 0; load_data = 0; start = 0; start_intt = 0; din = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || dout !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: done=%b dout=%0d expected 0 0", done, dout);
    end
    reset = 1'b0;
    check_quiet(5, "reset_idle");
  endtask

  task automatic test_ntt_delta();
    vec_t v, got;
    do_load_w();
    v = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    load_vec(v, -1);
    run_xform(1'b0, -1, "ntt_delta", got);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (got[k] !== 32'd1) begin
        n_fail++;
        $display("FAIL ntt_delta_const[%0d]: got %0d expected 1", k, got[k]);
      end
    end
  endtask

  task automatic test_ntt_zero();
    vec_t v, got;
    for (int k = 0; k < N; k++) v[k] = '0;
    load_vec(v, -1);
    run_xform(1'b0, -1, "ntt_zero", got);
  endtask

  task automatic test_intt_ones();
    vec_t v, got;
    for (int k = 0; k < N; k++) v[k] = 32'd1;
    load_vec(v, -1);
    run_xform(1'b1, -1, "intt_ones", got);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (got[k] !== ((k == 0) ? 32'd1 : 32'd0)) begin
        n_fail++;
        $display("FAIL intt_ones_delta[%0d]: got %0d expected %0d", k, got[k], (k == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_roundtrip();
    vec_t v, fwd, back;
    for (int k = 0; k < N; k++) v[k] = 32'($urandom_range(0, 16));
    load_vec(v, -1);
    run_xform(1'b0, -1, "rt_ntt", fwd);
    load_vec(fwd, -1);
    run_xform(1'b1, -1, "rt_intt", back);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (back[k] !== v[k]) begin
        n_fail++;
        $display("FAIL roundtrip[%0d]: got %0d expected %0d", k, back[k], v[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v, got;
    for (int k = 0; k < N; k++) v[k] = 32'(k + 2);
    load_vec(v, -1);
    run_xform(1'b0, -1, "b2b_first", got);
    run_xform(1'b0, -1, "b2b_second", got);
    run_xform(1'b1, -1, "b2b_inverse", got);
  endtask

  task automatic test_reset_midrun();
    vec_t v, got;
    int cycles;
    for (int k = 0; k < N; k++) v[k] = 32'(16 - k);
    load_vec(v, -1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (done !== 1'b0 || dout !== 32'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: done=%b dout=%0d expected 0 0", done, dout);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check_quiet(LAT_MAX + N, "midrun_no_done");

    // Reset while the result stream is showing non-zero data.
    do_load_w();
    v = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    load_vec(v, -1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < LAT_MAX) begin @(negedge clk); cycles++; end
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (dout !== 32'd1) begin
      n_fail++;
      $display("FAIL output_before_reset: dout=%0d expected 1", dout);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (dout !== 32'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL output_reset: dout=%0d done=%b expected 0 0", dout, done);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check_quiet(20, "output_reset_idle");

    do_load_w();
    for (int k = 0; k < N; k++) v[k] = 32'($urandom_range(0, 16));
    load_vec(v, -1);
    run_xform(1'b0, -1, "after_reset_ntt", got);
  endtask

  task automatic test_ignored_pulses();
    vec_t v, got;
    for (int k = 0; k < N; k++) v[k] = 32'((3 * k + 5) % 17);
    load_vec(v, 3);
    check_quiet(LAT_MAX, "start_in_load_d");
    run_xform(1'b0, 4, "start_in_output", got);
    check_quiet(LAT_MAX, "start_in_output_idle");
  endtask

  initial begin
    test_reset();
    test_ntt_delta();
    test_ntt_zero();
    test_intt_ones();
    test_roundtrip();
    test_back_to_back();
    test_reset_midrun();
    test_ignored_pulses();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
